// File: rtl/pwm_duty_decoder_pkg.sv
// Shared audio definitions: decoder FSM states and default widths/limits that
// must stay aligned with the PWM generator.
package pwm_duty_decoder_pkg;

  localparam int unsigned CNT_W_DEF       = 12;
  localparam int unsigned TIMEOUT_CYC_DEF = 4095;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_e;

endpackage

// File: rtl/pwm_duty_decoder_in_sync.sv
// Multi-flop synchroniser for an asynchronous io input, plus a rising-edge
// detect on the synchronised level.
module pwm_in_sync
  import pwm_duty_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic pwm_s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;

  // Synchroniser chain and one-cycle delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      pwm_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~pwm_d_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive decoder: measures high time and period between synchronised
// rising edges and delivers them over valid/ready with timeout and overrun flags.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] sample_o,
  output logic [CNT_W-1:0] period_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             timeout_o,
  output logic             level_o,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             pwm_s;
  logic             rise;

  dec_state_e       state_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic             emit_q;
  logic [CNT_W-1:0] emit_hi_q;
  logic [CNT_W-1:0] emit_per_q;
  logic             timeout_q;
  logic             level_q;

  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pwm_in),
    .pwm_s_o(pwm_s),
    .rise_o (rise)
  );

  // Measurement FSM; a completed period is staged in emit_* for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      hi_cnt_q     <= '0;
      emit_q       <= 1'b0;
      emit_hi_q    <= '0;
      emit_per_q   <= '0;
      timeout_q    <= 1'b0;
      level_q      <= 1'b0;
    end else if (!enable) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      hi_cnt_q     <= '0;
      emit_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q      <= ST_RUN;
            period_cnt_q <= CNT_ONE;
            hi_cnt_q     <= CNT_ONE;
            timeout_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (rise) begin
            emit_q       <= 1'b1;
            emit_hi_q    <= hi_cnt_q;
            emit_per_q   <= period_cnt_q;
            period_cnt_q <= CNT_ONE;
            hi_cnt_q     <= CNT_ONE;
          end else if (period_cnt_q == TIMEOUT_VAL) begin
            // Line is dead; drop the partial period and remember where it stuck
            state_q      <= ST_IDLE;
            timeout_q    <= 1'b1;
            level_q      <= pwm_s;
            period_cnt_q <= '0;
            hi_cnt_q     <= '0;
          end else begin
            period_cnt_q <= period_cnt_q + CNT_ONE;
            hi_cnt_q     <= hi_cnt_q + {{(CNT_W-1){1'b0}}, pwm_s};
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output handshake next state; overrun set beats a same-cycle clear
  always_comb begin
    sample_d  = sample_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_clr_i ? 1'b0 : overrun_q;
    if (!enable) begin
      valid_d = 1'b0;
    end else if (emit_q) begin
      if (!valid_q || sample_ready_i) begin
        sample_d = emit_hi_q;
        period_d = emit_per_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (sample_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output sample register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q  <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o       = sample_q;
  assign period_o       = period_q;
  assign sample_valid_o = valid_q;
  assign timeout_o      = timeout_q;
  assign level_o        = level_q;
  assign overrun_o      = overrun_q;

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the PWM audio generator: captures a single-bit PWM stream on an io input and recovers per-period duty (high time) and period length as samples.
- Used for on-chip loopback and self-test of the PWM output pins, and for decoding external PWM sources.
- Delivers samples over a valid/ready handshake.
- Flags dead-line (timeout) and dropped-sample (overrun) conditions.

Parameters:
- CNT_W, 12, width of the high-time and period counters and outputs.
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchroniser (legal values ≥ 2).
- TIMEOUT_CYC, 4095, number of cycles without a rising edge before timeout. Must be ≤ 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  decoder enable; when low the decoder is held in IDLE.
- pwm_in  input  1  asynchronous PWM input from the io pad.
- sample_o  output  CNT_W  high time of the last complete period, in clk cycles.
- period_o  output  CNT_W  length of the last complete period, in clk cycles.
- sample_valid_o  output  1  sample_o and period_o hold an unconsumed sample.
- sample_ready_i  input  1  consumer accepts the sample.
- timeout_o  output  1  level; no rising edge seen for TIMEOUT_CYC cycles.
- level_o  output  1  synchronised pwm level latched at timeout (0 = stuck low, 1 = stuck high).
- overrun_o  output  1  sticky; a sample was dropped.
- overrun_clr_i  input  1  clears overrun_o.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Synchroniser: pwm_in passes through SYNC_STAGES flops to give pwm_s. A one-flop delayed copy gives the rise detect: rise = pwm_s & ~pwm_d.
- FSM states:
  - IDLE: waits for rise.
  - RUN: measures a period.
- IDLE, on rise with enable=1: go to RUN; period_cnt=1; hi_cnt=1; clear timeout_o. No sample is emitted for this first edge.
- RUN, each cycle without rise: period_cnt+=1; hi_cnt+=pwm_s.
- RUN, on rise: emit sample with sample_o=hi_cnt and period_o=period_cnt; then period_cnt=1, hi_cnt=1.
  - The emitted period equals the cycle count between successive synchronised rising edges.
  - A 25% duty at period 100 yields 25/100.
- RUN timeout: when period_cnt==TIMEOUT_CYC and there is no rise, go to IDLE, set timeout_o=1, latch level_o=pwm_s, and emit no sample. Counters never wrap.
- Latency: a rising edge on pwm_in (setup met) at cycle N gives sample_valid_o=1 at cycle N+SYNC_STAGES+2.
- Output handshake:
  - A sample is transferred when sample_valid_o & sample_ready_i.
  - While valid=1, data holds stable.
  - Emit with valid=0: load the sample and set valid.
  - Emit with valid=1 and ready=0: drop the new sample, keep the old one, and set overrun_o.
  - Emit with valid=1 and ready=1 in the same cycle: load the new sample, valid stays 1, no overrun.
  - Ready with no emit: valid goes to 0.
- overrun_o: sticky until overrun_clr_i. If a set and a clear occur in the same cycle, set wins.
- enable=0: synchronous return to IDLE. Counters are cleared, sample_valid_o is flushed to 0, and timeout_o is cleared. overrun_o is retained. The synchroniser keeps running.
- Reset mid-period: everything returns to reset values immediately. A partial period is never emitted.
- Glitches shorter than one clk may be missed. The synchroniser gives no filtering beyond this.

Decomposition:
- Shared audio package:
  - FSM state enum (IDLE, RUN).
  - Default CNT_W, which must match the PWM generator counter width.
  - Default TIMEOUT_CYC.
- One sub-module: pwm_in_sync (SYNC_STAGES flop chain plus edge detect; outputs pwm_s and rise). It is reusable for the other io inputs.
- The FSM, counters and output register stay in the top module.

Test Plan:
- enable=1, ready=1; PWM with period 100 and high time 25, three periods → two samples, each sample_o=25 and period_o=100. The first edge yields no sample. Valid asserts SYNC_STAGES+2 cycles after each rising edge.
- Duty sweep: high time 1, 50, 99 at period 100 → sample_o = 1, 50, 99, each with period_o = 100.
- pwm_in held high after one rising edge with TIMEOUT_CYC=200 → at period_cnt=200: timeout_o=1, level_o=1, no sample. The next rising edge clears timeout_o.
- ready=0 across three periods → the first sample is held stable and overrun_o=1 after the second emit. overrun_clr_i=1 clears it. Ready=1 exactly on an emit cycle → new sample loaded, overrun_o stays 0.
- Reset asserted at cycle 50 of a 100-cycle period, released, then two clean periods of 80 with high time 40 → no partial sample; one sample 40/80.
- enable dropped while valid=1 → valid=0 next cycle, overrun_o retained. Re-enable → the first edge again yields no sample.
